// File: rtl/nn_pkg.sv
// Shared types and helpers for the neural-navigator neuron datapath.
package nn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } nn_mac_state_t;

    localparam int NN_DATA_W = 8;
    localparam int NN_ACC_W  = 20;

    typedef struct packed {
        logic signed [63:0] val;
        logic               sat;
    } sat_res_t;

    // Clamp a wide signed value into a width-bit signed range.
    function automatic sat_res_t sat_narrow(
        input logic signed [63:0] v,
        input int                 w
    );
        sat_res_t           r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        r.sat = 1'b1;
        if (v > hi) begin
            r.val = hi;
        end else if (v < lo) begin
            r.val = lo;
        end else begin
            r.val = v;
            r.sat = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/nn_neuron_mac_if.sv
// Input beat and output result handshakes of the neuron MAC.
interface nn_neuron_mac_if #(
    parameter int DATA_W = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_x;
    logic signed [DATA_W-1:0] in_w;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_sat;

    modport slave (
        input  in_valid, in_x, in_w, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );

    modport master (
        output in_valid, in_x, in_w, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/nn_sat.sv
// Signed saturator from IN_W down to OUT_W bits with overflow flag.
module nn_sat #(
    parameter int IN_W  = 21,
    parameter int OUT_W = 8
) (
    input  logic signed [IN_W-1:0]  in_i,
    output logic signed [OUT_W-1:0] out_o,
    output logic                    sat_o
);
    logic [IN_W-OUT_W:0] hi;

    assign hi    = in_i[IN_W-1:OUT_W-1];
    assign sat_o = !((&hi) || !(|hi));
    assign out_o = sat_o
        ? {in_i[IN_W-1], {(OUT_W-1){~in_i[IN_W-1]}}}
        : in_i[OUT_W-1:0];
endmodule

// File: rtl/nn_neuron_mac.sv
// Serial signed MAC neuron with bias, shift and saturation.
// Define NN_NEURON_RELU_EN to clamp negative results to zero.
module nn_neuron_mac
    import nn_pkg::*;
#(
    parameter int DATA_W   = NN_DATA_W,
    parameter int ACC_W    = NN_ACC_W,
    parameter int N_INPUTS = 4,
    parameter int SHIFT    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bias_we,
    input  logic signed [DATA_W-1:0] bias_in,
    nn_neuron_mac_if.slave           io
);
    localparam int CNT_W = $clog2(N_INPUTS + 1);

    nn_mac_state_t state_q, state_d;

    logic signed [ACC_W-1:0]    acc_q;
    logic [CNT_W-1:0]           cnt_q;
    logic signed [DATA_W-1:0]   bias_q;
    logic                       sticky_q;
    logic signed [DATA_W-1:0]   out_data_q;
    logic                       out_sat_q;

    logic                       in_rdy;
    logic                       out_vld;
    logic                       accept;
    logic                       fin;
    logic                       ovf;
    logic                       res_sat;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    base;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [ACC_W:0]      biased;
    logic signed [ACC_W:0]      shifted;
    logic signed [DATA_W-1:0]   res_clip;
    logic signed [DATA_W-1:0]   res;
    sat_res_t                   acc_s;

    assign prod   = io.in_x * io.in_w;
    assign accept = io.in_valid & in_rdy;
    assign fin    = accept & (io.in_last |
                    (cnt_q == CNT_W'(N_INPUTS - 1)));

    // First beat starts from zero; later beats clamp, never wrap.
    always_comb begin
        base    = (state_q == ACCUM) ? acc_q : '0;
        acc_s   = sat_narrow(64'(base) + 64'(prod), ACC_W);
        acc_d   = acc_s.val[ACC_W-1:0];
        ovf     = acc_s.sat;
        biased  = (ACC_W+1)'(acc_d) + (ACC_W+1)'(bias_q);
        shifted = biased >>> SHIFT;
    end

    nn_sat #(
        .IN_W  (ACC_W + 1),
        .OUT_W (DATA_W)
    ) u_sat (
        .in_i  (shifted),
        .out_o (res_clip),
        .sat_o (res_sat)
    );

`ifdef NN_NEURON_RELU_EN
    assign res = res_clip[DATA_W-1] ? '0 : res_clip;
`else
    assign res = res_clip;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = fin ? OUTPUT : ACCUM;
            ACCUM:   if (fin) state_d = OUTPUT;
            OUTPUT:  if (io.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_rdy  = (state_q != OUTPUT);
        out_vld = (state_q == OUTPUT);
    end

    assign io.in_ready  = in_rdy;
    assign io.out_valid = out_vld;
    assign io.out_data  = out_data_q;
    assign io.out_sat   = out_sat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            bias_q     <= '0;
            sticky_q   <= 1'b0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            if (bias_we) bias_q <= bias_in;
            if (accept) begin
                acc_q    <= acc_d;
                cnt_q    <= cnt_q + CNT_W'(1);
                sticky_q <= sticky_q | ovf;
            end
            if (fin) begin
                out_data_q <= res;
                out_sat_q  <= sticky_q | ovf | res_sat;
            end
            if (out_vld && io.out_ready) begin
                acc_q    <= '0;
                cnt_q    <= '0;
                sticky_q <= 1'b0;
            end
        end
    end
endmodule
